// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the THCO fetch path: word widths, NOP encoding,
// fetch FSM state encoding and the {pc,instr} entry held in the prefetch FIFO.
package fetch_queue_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO of {pc,instr} pairs for the fetch queue.
// Head entry is read straight from slot registers so the ID outputs come
// from registered state. clear empties the queue and overrides push/pop.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  fetch_entry_t     slot_data [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t slot_reg;

      // Capture the incoming pair when this slot is the write target.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          slot_reg <= '0;
        else if (push && !clear && (wr_ptr_reg == PTR_W'(gi)))
          slot_reg <= din;
      end

      assign slot_data[gi] = slot_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = slot_data[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// PC generator and instruction prefetch queue for the THCO pipeline.
// Fetches from combinational instruction memory, replays the same PC on
// SRAM conflicts, buffers words against ID stalls and flushes on redirect.
// Optional FETCH_PERF_EN adds saturating fetch / conflict counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_conflict,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_W-1:0]     id_instr,
  output logic [ADDR_W-1:0]      id_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]            perf_fetch_cnt,
  output logic [15:0]            perf_conflict_cnt,
`endif
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic              run_en;
  logic [ADDR_W-1:0] pc_reg;
  logic              pop;
  logic              has_room;
  logic              fetch_ok;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [CNT_W-1:0]  fifo_count;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= ST_BOOT;
    else
      state_reg <= state_next;
  end

  // One settling cycle in BOOT, then RUN forever.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // Fetching is only permitted in RUN.
  always_comb begin
    run_en = (state_reg == ST_RUN);
  end

  assign pop      = id_valid & id_ready;
  assign has_room = (fifo_count < CNT_W'(DEPTH)) | pop;
  assign fetch_ok = run_en & ~mem_conflict & ~redirect_valid & has_room;

  // PC: redirect wins, otherwise advance only on an accepted fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_reg <= RESET_PC;
    else if (redirect_valid)
      pc_reg <= redirect_pc;
    else if (fetch_ok)
      pc_reg <= pc_reg + PC_STEP;
  end

  assign imem_addr  = pc_reg;
  assign push_entry = '{pc: pc_reg, instr: imem_data};

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_ok),
    .pop   (pop & ~redirect_valid),
    .clear (redirect_valid),
    .din   (push_entry),
    .head  (head_entry),
    .count (fifo_count)
  );

  assign occupancy = fifo_count;
  assign id_valid  = (fifo_count != '0);
  assign id_instr  = id_valid ? head_entry.instr : NOP_INSTR;
  assign id_pc     = id_valid ? head_entry.pc : '0;

`ifdef FETCH_PERF_EN
  // Saturating counters of accepted fetches and conflict-blocked RUN cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (fetch_ok)
        perf_fetch_cnt <= sat_inc16(perf_fetch_cnt);
      if (run_en && mem_conflict && !redirect_valid)
        perf_conflict_cnt <= sat_inc16(perf_conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table of per-cycle vectors covering
// start-up, stall/full, conflict replay, redirect and PC wrap, followed by
// hand sequences for asynchronous mid-run reset and the perf counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_conflict = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [2:0]  occupancy;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_conflict_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word content derived from its address.
  assign imem_data = imem_addr ^ 16'h5A00;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (16'h0000),
    .PC_STEP  (16'd1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_conflict   (mem_conflict),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .occupancy      (occupancy)
  );

  typedef struct {
    logic        conf;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tv [24];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every observable output against one expected cycle state.
  task automatic chk_state(input int idx, input logic [15:0] e_addr, input logic e_valid,
                           input logic [15:0] e_pc, input logic [2:0] e_occ);
    logic [15:0] e_instr;
    e_instr = e_valid ? (e_pc ^ 16'h5A00) : 16'h0800;
    chk($sformatf("v%0d imem_addr", idx), imem_addr, e_addr);
    chk($sformatf("v%0d id_valid", idx), {15'd0, id_valid}, {15'd0, e_valid});
    chk($sformatf("v%0d id_pc", idx), id_pc, e_pc);
    chk($sformatf("v%0d id_instr", idx), id_instr, e_instr);
    chk($sformatf("v%0d occupancy", idx), {13'd0, occupancy}, {13'd0, e_occ});
  endtask

  initial begin
    //           conf redir rpc       rdy  addr      v  id_pc     occ
    tv[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0}; // BOOT
    tv[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0}; // first fetch
    tv[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'h0000, 3'd1};
    tv[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0000, 3'd2};
    tv[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h0000, 3'd3};
    tv[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 3'd4}; // full
    tv[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 3'd4};
    tv[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0000, 3'd4};
    tv[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 3'd4}; // push+pop when full
    tv[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0001, 3'd4}; // conflict
    tv[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0002, 3'd3}; // conflict
    tv[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0003, 3'd2}; // replay pc 5
    tv[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0004, 3'd2};
    tv[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 1'b1, 16'h0005, 3'd2};
    tv[14] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0008, 1'b1, 16'h0005, 3'd3}; // redirect + pop
    tv[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 3'd0};
    tv[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h0040, 3'd1};
    tv[17] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0042, 1'b1, 16'h0041, 3'd1}; // redirect to FFFF
    tv[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 3'd0};
    tv[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 3'd1}; // pc wrapped
    tv[20] = '{1'b1, 1'b1, 16'h0100, 1'b1, 16'h0001, 1'b1, 16'h0000, 3'd1}; // redirect beats conflict
    tv[21] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 3'd0};
    tv[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 3'd0};
    tv[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b1, 16'h0100, 3'd1};

    // Reset held: outputs must show the empty/idle state.
    tick();
    tick();
    chk_state(-1, 16'h0000, 1'b0, 16'h0000, 3'd0);
    $display("reset: addr=%h valid=%b occ=%0d", imem_addr, id_valid, occupancy);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      mem_conflict   = tv[i].conf;
      redirect_valid = tv[i].redir;
      redirect_pc    = tv[i].rpc;
      id_ready       = tv[i].rdy;
      chk_state(i, tv[i].e_addr, tv[i].e_valid, tv[i].e_pc, tv[i].e_occ);
      $display("vec %0d: addr=%h valid=%b id_pc=%h instr=%h occ=%0d", i, imem_addr, id_valid,
               id_pc, id_instr, occupancy);
      tick();
    end
    mem_conflict   = 1'b0;
    redirect_valid = 1'b0;

    // Mid-cycle reset: queue and pc cleared without waiting for a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_state(100, 16'h0000, 1'b0, 16'h0000, 3'd0);
`ifdef FETCH_PERF_EN
    chk("async perf_fetch_cnt", perf_fetch_cnt, 16'd0);
    chk("async perf_conflict_cnt", perf_conflict_cnt, 16'd0);
`endif
    $display("async reset: addr=%h valid=%b occ=%0d", imem_addr, id_valid, occupancy);
    tick();
    rst = 1'b1;

    // Free run: BOOT, 10 accepted fetches, then 3 conflict cycles.
    id_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    mem_conflict = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_conflict = 1'b0;
    chk("run imem_addr", imem_addr, 16'h000A);
    chk("run occupancy", {13'd0, occupancy}, 16'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 16'd10);
    chk("perf_conflict_cnt", perf_conflict_cnt, 16'd3);
    $display("perf: fetch=%0d conflict=%0d", perf_fetch_cnt, perf_conflict_cnt);
    #2;
    rst = 1'b0;
    #1;
    chk("perf clear fetch", perf_fetch_cnt, 16'd0);
    chk("perf clear conflict", perf_conflict_cnt, 16'd0);
    rst = 1'b1;
`endif
    $display("run: addr=%h occ=%0d", imem_addr, occupancy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
